// File: rtl/pipe_add_sub_if.sv
// Streaming operand/result bundle for the pipelined adder/subtractor.
// The master side drives operands and consumes results; the slave side
// is the arithmetic block itself.
interface pipe_add_sub_if #(
    parameter int WIDTH = 16
);
    // Input side: operands and their handshake
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_1;
    logic [WIDTH-1:0] d_2;
    logic             sub;
    logic             Cin;

    // Output side: result and its handshake
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, d_1, d_2, sub, Cin, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf
    );

    modport slave (
        input  in_valid, d_1, d_2, sub, Cin, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf
    );
endinterface

// File: rtl/pipe_add_sub.sv
// Pipelined adder/subtractor.
// The WIDTH-bit carry chain is cut into STAGES chunks of CW bits. Stage k adds
// the lowest remaining chunk of both operands plus the carry from stage k-1.
// Remaining operand bits travel down the pipe shifted right by CW each stage,
// and finished result chunks enter the partial sum from the top and shift
// down, so after STAGES stages chunk 0 sits at bit 0 and everything aligns.
// Backpressure stalls the whole pipe; bubbles travel as valid=0 slots.
module pipe_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_add_sub_if.slave bus
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Adds one CW-bit chunk plus carry; returns {carry_out, sum_chunk}.
    function automatic logic [CW:0] chunk_add(
        input logic [CW-1:0] a,
        input logic [CW-1:0] b,
        input logic          c
    );
        chunk_add = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, c};
    endfunction

    // Signed overflow of a chunk sum: carry into its MSB xor carry out of it.
    // The carry into the MSB is recovered from sum_msb ^ a_msb ^ b_msb.
    function automatic logic chunk_ovf(
        input logic [CW:0]   res,
        input logic [CW-1:0] a,
        input logic [CW-1:0] b
    );
        chunk_ovf = (res[CW-1] ^ a[CW-1] ^ b[CW-1]) ^ res[CW];
    endfunction

    // Per-stage pipeline registers
    logic [WIDTH-1:0] a_r     [STAGES];
    logic [WIDTH-1:0] b_r     [STAGES];
    logic [WIDTH-1:0] sum_r   [STAGES];
    logic             carry_r [STAGES];
    logic             valid_r [STAGES];
    logic             ovf_r;

    // Per-stage combinational inputs and next values
    logic [WIDTH-1:0] a_in_s     [STAGES];
    logic [WIDTH-1:0] b_in_s     [STAGES];
    logic [WIDTH-1:0] sum_in_s   [STAGES];
    logic             c_in_s     [STAGES];
    logic             v_in_s     [STAGES];
    logic [CW:0]      chunk_s    [STAGES];
    logic [WIDTH-1:0] top_s      [STAGES];
    logic [WIDTH-1:0] a_next_s   [STAGES];
    logic [WIDTH-1:0] b_next_s   [STAGES];
    logic [WIDTH-1:0] sum_next_s [STAGES];
    logic             ovf_next_s;

    logic stall_s;
    logic accept_s;

    assign stall_s  = valid_r[LAST] & ~bus.out_ready;
    assign accept_s = bus.in_valid & rst_n & ~stall_s;

    assign bus.in_ready  = rst_n & ~stall_s;
    assign bus.out_valid = valid_r[LAST];
    assign bus.Sum       = sum_r[LAST];
    assign bus.Cout      = carry_r[LAST];
    assign bus.Ovf       = ovf_r;

    // Stage inputs: stage 0 takes the prepared operands, later stages the previous registers
    always_comb begin
        a_in_s[0]   = bus.d_1;
        b_in_s[0]   = bus.sub ? ~bus.d_2 : bus.d_2;
        c_in_s[0]   = bus.sub ? ~bus.Cin : bus.Cin;
        sum_in_s[0] = '0;
        v_in_s[0]   = accept_s;
        for (int k = 1; k < STAGES; k++) begin
            a_in_s[k]   = a_r[k-1];
            b_in_s[k]   = b_r[k-1];
            c_in_s[k]   = carry_r[k-1];
            sum_in_s[k] = sum_r[k-1];
            v_in_s[k]   = valid_r[k-1];
        end
    end

    // Chunk addition and shift-down of operands / partial sum for every stage
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            chunk_s[k]                = chunk_add(a_in_s[k][CW-1:0], b_in_s[k][CW-1:0], c_in_s[k]);
            a_next_s[k]               = a_in_s[k] >> CW;
            b_next_s[k]               = b_in_s[k] >> CW;
            top_s[k]                  = '0;
            top_s[k][WIDTH-1 -: CW]   = chunk_s[k][CW-1:0];
            sum_next_s[k]             = (sum_in_s[k] >> CW) | top_s[k];
        end
        ovf_next_s = chunk_ovf(chunk_s[LAST], a_in_s[LAST][CW-1:0], b_in_s[LAST][CW-1:0]);
    end

    // Pipeline registers: clear on reset, hold on stall, load data only for valid slots
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]     <= '0;
                b_r[k]     <= '0;
                sum_r[k]   <= '0;
                carry_r[k] <= 1'b0;
                valid_r[k] <= 1'b0;
            end
            ovf_r <= 1'b0;
        end else if (!stall_s) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= v_in_s[k];
                if (v_in_s[k]) begin
                    a_r[k]     <= a_next_s[k];
                    b_r[k]     <= b_next_s[k];
                    sum_r[k]   <= sum_next_s[k];
                    carry_r[k] <= chunk_s[k][CW];
                end else begin
                    a_r[k]     <= a_r[k];
                    b_r[k]     <= b_r[k];
                    sum_r[k]   <= sum_r[k];
                    carry_r[k] <= carry_r[k];
                end
            end
            if (v_in_s[LAST]) begin
                ovf_r <= ovf_next_s;
            end else begin
                ovf_r <= ovf_r;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                valid_r[k] <= valid_r[k];
                a_r[k]     <= a_r[k];
                b_r[k]     <= b_r[k];
                sum_r[k]   <= sum_r[k];
                carry_r[k] <= carry_r[k];
            end
            ovf_r <= ovf_r;
        end
    end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub: directed vector table on the
// 16/4 configuration, streaming on 16/4, 16/1 and 32/8, plus backpressure
// and mid-flight reset sequences.
module tb_pipe_add_sub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_add_sub_if #(.WIDTH(16)) if0 ();
    pipe_add_sub_if #(.WIDTH(16)) if1 ();
    pipe_add_sub_if #(.WIDTH(32)) if2 ();

    pipe_add_sub #(.WIDTH(16), .STAGES(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    pipe_add_sub #(.WIDTH(16), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    pipe_add_sub #(.WIDTH(32), .STAGES(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands
    function automatic void model(input longint unsigned a_in, input longint unsigned b_in,
                                  input bit s, input bit c, input int w,
                                  output longint unsigned sum, output bit cout, output bit ovf);
        longint unsigned m, a, b, full;
        longint sa, sb, sr, smax, smin;
        m    = (64'd1 << w) - 64'd1;
        a    = a_in & m;
        b    = b_in & m;
        sa   = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        sb   = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
        smax = longint'(64'd1 << (w-1)) - 64'sd1;
        smin = -longint'(64'd1 << (w-1));
        if (!s) begin
            full = a + b + longint'(c);
            sum  = full & m;
            cout = full[w];
            sr   = sa + sb + longint'(c);
        end else begin
            sum  = (a - b - longint'(c)) & m;
            cout = (a >= b + longint'(c));
            sr   = sa - sb - longint'(c);
        end
        ovf = (sr > smax) || (sr < smin);
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic        c;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    // Scoreboard for the 16/4 sequences
    logic [15:0] q_sum[$];
    bit          q_co[$];
    bit          q_ov[$];
    int          drained;

    task automatic step0(input bit iv, input logic [15:0] a, input logic [15:0] b,
                         input bit s, input bit c, input bit ordy, output bit acc);
        longint unsigned es;
        bit ec, eo;
        @(negedge clk);
        if0.in_valid  = iv;
        if0.d_1       = a;
        if0.d_2       = b;
        if0.sub       = s;
        if0.Cin       = c;
        if0.out_ready = ordy;
        #1;
        acc = iv && if0.in_ready;
        if (acc) begin
            model(a, b, s, c, 16, es, ec, eo);
            q_sum.push_back(es[15:0]);
            q_co.push_back(ec);
            q_ov.push_back(eo);
        end
        if (if0.out_valid && if0.out_ready) begin
            check("sb_nonempty", q_sum.size() != 0, 1);
            if (q_sum.size() != 0) begin
                check("sb_sum", if0.Sum, q_sum.pop_front());
                check("sb_cout", if0.Cout, q_co.pop_front());
                check("sb_ovf", if0.Ovf, q_ov.pop_front());
                drained++;
            end
        end
    endtask

    task automatic stream_cmp(input string tag, input int idx, input bit ov,
                              input longint unsigned sum, input bit co, input bit of,
                              input longint unsigned es, input bit ec, input bit eo);
        bit exp_v;
        exp_v = (idx >= 0) && (idx < 8);
        check({tag, "_valid"}, ov, exp_v);
        if (exp_v) begin
            check({tag, "_sum"}, sum, es);
            check({tag, "_cout"}, co, ec);
            check({tag, "_ovf"}, of, eo);
        end
    endtask

    logic [31:0]     sa_op[8];
    logic [31:0]     sb_op[8];
    bit              ss_op[8];
    bit              sc_op[8];
    longint unsigned e16_sum[8];
    bit              e16_co[8];
    bit              e16_ov[8];
    longint unsigned e32_sum[8];
    bit              e32_co[8];
    bit              e32_ov[8];

    initial begin
        bit          acc;
        bit          acc4;
        int          lat;
        logic [15:0] hold_sum;
        logic        hold_co;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[6]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[10] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[11] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        // Reset with in_valid asserted on the 16/4 unit
        rst_n = 1'b0;
        drained = 0;
        if0.in_valid = 1'b1; if0.d_1 = 16'h1234; if0.d_2 = 16'h1111;
        if0.sub = 1'b0; if0.Cin = 1'b0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.d_1 = '0; if1.d_2 = '0; if1.sub = 1'b0; if1.Cin = 1'b0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.d_1 = '0; if2.d_2 = '0; if2.sub = 1'b0; if2.Cin = 1'b0; if2.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", if0.in_ready, 0);
        check("rst_out_valid", if0.out_valid, 0);
        check("rst_sum", if0.Sum, 0);
        check("rst_cout", if0.Cout, 0);
        check("rst_ovf", if0.Ovf, 0);
        check("rst_out_valid_s1", if1.out_valid, 0);
        check("rst_out_valid_s8", if2.out_valid, 0);
        rst_n = 1'b1;
        if0.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_out", if0.out_valid, 0);
        end

        // Directed vectors, one at a time, with latency measurement
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if0.in_valid = 1'b1;
            if0.d_1 = vecs[i].a; if0.d_2 = vecs[i].b;
            if0.sub = vecs[i].s; if0.Cin = vecs[i].c;
            #1;
            check("vec_in_ready", if0.in_ready, 1);
            @(negedge clk);
            if0.in_valid = 1'b0;
            lat = 1;
            while (!if0.out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check("vec_latency", lat, 4);
            check("vec_sum", if0.Sum, vecs[i].sum);
            check("vec_cout", if0.Cout, vecs[i].cout);
            check("vec_ovf", if0.Ovf, vecs[i].ovf);
        end

        // Streaming on all three configurations in parallel
        for (int i = 0; i < 8; i++) begin
            sa_op[i] = $urandom;
            sb_op[i] = $urandom;
            ss_op[i] = 1'($urandom_range(1, 0));
            sc_op[i] = 1'($urandom_range(1, 0));
            model(longint'(sa_op[i][15:0]), longint'(sb_op[i][15:0]), ss_op[i], sc_op[i], 16,
                  e16_sum[i], e16_co[i], e16_ov[i]);
            model(longint'(sa_op[i]), longint'(sb_op[i]), ss_op[i], sc_op[i], 32,
                  e32_sum[i], e32_co[i], e32_ov[i]);
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            stream_cmp("strm_s4", t - 4, if0.out_valid, if0.Sum, if0.Cout, if0.Ovf,
                       e16_sum[(t - 4) & 7], e16_co[(t - 4) & 7], e16_ov[(t - 4) & 7]);
            stream_cmp("strm_s1", t - 1, if1.out_valid, if1.Sum, if1.Cout, if1.Ovf,
                       e16_sum[(t - 1) & 7], e16_co[(t - 1) & 7], e16_ov[(t - 1) & 7]);
            stream_cmp("strm_w32", t - 8, if2.out_valid, if2.Sum, if2.Cout, if2.Ovf,
                       e32_sum[(t - 8) & 7], e32_co[(t - 8) & 7], e32_ov[(t - 8) & 7]);
            if (t < 8) begin
                if0.in_valid = 1'b1; if0.d_1 = sa_op[t][15:0]; if0.d_2 = sb_op[t][15:0];
                if0.sub = ss_op[t]; if0.Cin = sc_op[t];
                if1.in_valid = 1'b1; if1.d_1 = sa_op[t][15:0]; if1.d_2 = sb_op[t][15:0];
                if1.sub = ss_op[t]; if1.Cin = sc_op[t];
                if2.in_valid = 1'b1; if2.d_1 = sa_op[t]; if2.d_2 = sb_op[t];
                if2.sub = ss_op[t]; if2.Cin = sc_op[t];
            end else begin
                if0.in_valid = 1'b0;
                if1.in_valid = 1'b0;
                if2.in_valid = 1'b0;
            end
        end

        // Backpressure: fill the 16/4 pipe, hold out_ready low 3 cycles, then drain
        drained = 0;
        for (int i = 0; i < 4; i++) begin
            step0(1'b1, 16'h1111 * 16'(i + 1), 16'h0101, 1'(i), 1'b0, 1'b0, acc);
            check("bp_fill_acc", acc, 1);
        end
        for (int i = 0; i < 3; i++) begin
            step0(1'b1, 16'h1234, 16'h0101, 1'b0, 1'b0, 1'b0, acc);
            check("bp_in_ready", if0.in_ready, 0);
            check("bp_out_valid", if0.out_valid, 1);
            if (i == 0) begin
                hold_sum = if0.Sum;
                hold_co  = if0.Cout;
                check("bp_head_sum", if0.Sum, q_sum[0]);
            end else begin
                check("bp_sum_stable", if0.Sum, hold_sum);
                check("bp_cout_stable", if0.Cout, hold_co);
            end
        end
        acc4 = 1'b0;
        for (int n = 0; n < 20 && drained < 5; n++) begin
            step0(!acc4, 16'h1234, 16'h0101, 1'b0, 1'b0, 1'b1, acc);
            if (acc) acc4 = 1'b1;
        end
        check("bp_drained", drained, 5);
        check("bp_queue_empty", q_sum.size(), 0);

        // Reset mid-flight with three ops in the pipe
        for (int i = 0; i < 3; i++) begin
            step0(1'b1, 16'h2222 + 16'(i), 16'h0003, 1'b0, 1'b1, 1'b1, acc);
        end
        @(negedge clk);
        rst_n = 1'b0;
        if0.in_valid = 1'b0;
        #1;
        check("mid_rst_in_ready", if0.in_ready, 0);
        @(negedge clk);
        check("mid_rst_out_valid", if0.out_valid, 0);
        check("mid_rst_sum", if0.Sum, 0);
        check("mid_rst_cout", if0.Cout, 0);
        check("mid_rst_ovf", if0.Ovf, 0);
        rst_n = 1'b1;
        q_sum.delete();
        q_co.delete();
        q_ov.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("mid_rst_no_stale", if0.out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
